// File: rtl/bcd_up_timer_pkg.sv
// Shared types and limits for the MM:SS elapsed-time counter.
package bcd_up_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] DIG_MAX   = 4'd9;
    localparam logic [3:0] SEC_T_MAX = 4'd5;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
    } mmss_t;

    function automatic logic mmss_ok(mmss_t t);
        return (t.min_t <= DIG_MAX) && (t.min_u <= DIG_MAX) &&
               (t.sec_t <= SEC_T_MAX) && (t.sec_u <= DIG_MAX);
    endfunction

endpackage

// File: rtl/bcd_up_timer_zero_to_nine_en.sv
// One decade up-counter with enable, sync clear and a wrap carry.
// nxt is the value the digit takes on this edge, used for target compare.
module zero_to_nine_en
    import bcd_up_timer_pkg::*;
#(
    parameter logic [3:0] MAX = DIG_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic [3:0] nxt,
    output logic       carry
);

    assign carry = en && (q == MAX);

    always_comb begin
        nxt = q;
        if (en) begin
            nxt = (q == MAX) ? 4'd0 : q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (en) begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/bcd_up_timer.sv
// Four-digit BCD MM:SS elapsed-time counter with programmable target.
// Prescaler, run/pause/done FSM, target register and pulse outputs.
module bcd_up_timer
    import bcd_up_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       load_target,
    input  logic [3:0] target_min_t,
    input  logic [3:0] target_min_u,
    input  logic [3:0] target_sec_t,
    input  logic [3:0] target_sec_u,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       tick_1hz,
    output logic       running,
    output logic       done,
    output logic       target_err
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

    state_t        state;
    logic [PW-1:0] presc;
    mmss_t         target;
    mmss_t         tgt_in;
    mmss_t         cnt_nxt;
    logic          step;
    logic          match;
    logic          c0, c1, c2, c3;

    assign tgt_in = '{target_min_t, target_min_u,
                      target_sec_t, target_sec_u};

    // pause and clear win over the second boundary on the same edge
    assign step = (state == ST_RUN) && !clear && !pause &&
                  (presc == PRE_MAX);

    zero_to_nine_en #(.MAX(DIG_MAX)) u_sec_u (
        .clk(clk), .rst_n(rst_n), .en(step), .clr(clear),
        .q(sec_u), .nxt(cnt_nxt.sec_u), .carry(c0)
    );

    zero_to_nine_en #(.MAX(SEC_T_MAX)) u_sec_t (
        .clk(clk), .rst_n(rst_n), .en(c0), .clr(clear),
        .q(sec_t), .nxt(cnt_nxt.sec_t), .carry(c1)
    );

    zero_to_nine_en #(.MAX(DIG_MAX)) u_min_u (
        .clk(clk), .rst_n(rst_n), .en(c1), .clr(clear),
        .q(min_u), .nxt(cnt_nxt.min_u), .carry(c2)
    );

    zero_to_nine_en #(.MAX(DIG_MAX)) u_min_t (
        .clk(clk), .rst_n(rst_n), .en(c2), .clr(clear),
        .q(min_t), .nxt(cnt_nxt.min_t), .carry(c3)
    );

    // a 99:59 rollover lands on 00:00, which never counts as a target
    assign match = step && !c3 && (target != '0) && (cnt_nxt == target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            presc      <= '0;
            target     <= '0;
            tick_1hz   <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
            target_err <= 1'b0;
        end else begin
            tick_1hz   <= 1'b0;
            target_err <= 1'b0;
            if (clear) begin
                state   <= ST_IDLE;
                presc   <= '0;
                running <= 1'b0;
                done    <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE, ST_DONE: begin
                        if (load_target) begin
                            if (mmss_ok(tgt_in)) begin
                                target <= tgt_in;
                            end else begin
                                target_err <= 1'b1;
                            end
                        end else if (state == ST_IDLE && start && !pause) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (pause) begin
                            state   <= ST_PAUSE;
                            running <= 1'b0;
                        end else if (presc == PRE_MAX) begin
                            presc    <= '0;
                            tick_1hz <= 1'b1;
                            if (match) begin
                                state   <= ST_DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                            end
                        end else begin
                            presc <= presc + PW'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (!pause && start) begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_up_timer.sv
// Scoreboard bench for bcd_up_timer: seconds-based model, queue, monitor.
module tb_bcd_up_timer;

    localparam int T = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic       load_target = 1'b0;
    logic [3:0] tmt = 4'd0;
    logic [3:0] tmu = 4'd0;
    logic [3:0] tst = 4'd0;
    logic [3:0] tsu = 4'd0;
    logic [3:0] min_t, min_u, sec_t, sec_u;
    logic       tick_1hz, running, done, target_err;

    bcd_up_timer #(.TICKS_PER_SEC(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
        .clear(clear), .load_target(load_target),
        .target_min_t(tmt), .target_min_u(tmu),
        .target_sec_t(tst), .target_sec_u(tsu),
        .min_t(min_t), .min_u(min_u), .sec_t(sec_t), .sec_u(sec_u),
        .tick_1hz(tick_1hz), .running(running), .done(done),
        .target_err(target_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int secs;
        bit tick;
        bit run;
        bit dn;
        bit err;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    int m_secs = 0;
    int m_sub = 0;
    int m_mode = M_IDLE;
    int m_tgt = 0;
    bit m_tick = 0;
    bit m_err = 0;

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s actual=%0h required=%0h t=%0t",
                         name, act, req, $time);
        end
    endtask

    function automatic int bcd(int s);
        int w;
        w = s % 6000;
        return ((w / 600) << 12) | (((w / 60) % 10) << 8) |
               (((w % 60) / 10) << 4) | (w % 10);
    endfunction

    function automatic bit tgt_ok();
        return tmt < 10 && tmu < 10 && tst < 6 && tsu < 10;
    endfunction

    task automatic model_reset();
        m_secs = 0; m_sub = 0; m_mode = M_IDLE;
        m_tgt = 0; m_tick = 0; m_err = 0;
    endtask

    task automatic model_edge();
        exp_t e;
        m_tick = 0;
        m_err = 0;
        if (clear) begin
            m_secs = 0;
            m_sub = 0;
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: begin
                    if (load_target) begin
                        if (tgt_ok())
                            m_tgt = int'(tmt) * 600 + int'(tmu) * 60 +
                                    int'(tst) * 10 + int'(tsu);
                        else
                            m_err = 1;
                    end else if (m_mode == M_IDLE && start && !pause) begin
                        m_mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (pause) begin
                        m_mode = M_PAUSE;
                    end else if (m_sub == T - 1) begin
                        m_sub = 0;
                        m_secs = (m_secs + 1) % 6000;
                        m_tick = 1;
                        if (m_tgt != 0 && m_secs == m_tgt) m_mode = M_DONE;
                    end else begin
                        m_sub++;
                    end
                end
                default: if (!pause && start) m_mode = M_RUN;
            endcase
        end
        e.secs = m_secs;
        e.tick = m_tick;
        e.run = (m_mode == M_RUN);
        e.dn = (m_mode == M_DONE);
        e.err = m_err;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic load(int a, int b, int c, int d);
        tmt = 4'(a); tmu = 4'(b); tst = 4'(c); tsu = 4'(d);
        load_target = 1'b1;
        step();
        load_target = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("digits", {min_t, min_u, sec_t, sec_u}, bcd(e.secs));
            check("flags", {tick_1hz, running, done, target_err},
                  {e.tick, e.run, e.dn, e.err});
        end
    end

    initial begin
        int n;
        int prev;
        bit wrapped;
        model_reset();
        #2;
        check("reset_outputs", {min_t, min_u, sec_t, sec_u,
              tick_1hz, running, done, target_err}, 0);
        rst_n = 1'b1;
        step();

        // 1: target 00:03, done after 3*T edges
        load(0, 0, 0, 3);
        pulse_start();
        n = 0;
        while (!done && n < 40) begin step(); n++; end
        check("t1_latency", n, 3 * T);
        check("t1_sec_u", sec_u, 3);
        check("t1_running", running, 0);
        pause = 1'b1; start = 1'b1; step(); step();
        pause = 1'b0; start = 1'b0;

        // 5: rejected loads in IDLE, ignored load in RUN
        do_clear();
        load(0, 0, 6, 0);
        check("t5_err_sec_t", target_err, 1);
        step();
        check("t5_err_pulse", target_err, 0);
        load(0, 10, 0, 0);
        check("t5_err_min_u", target_err, 1);
        load(0, 0, 0, 2);
        pulse_start();
        load(0, 0, 0, 5);
        check("t5_run_load", target_err, 0);
        n = 0;
        while (!done && n < 40) begin step(); n++; end
        check("t5_done", done, 1);

        // 4: clear+load together keeps old target; start+pause combos
        clear = 1'b1;
        load(0, 0, 0, 4);
        clear = 1'b0;
        start = 1'b1; pause = 1'b1; step();
        start = 1'b0; pause = 1'b0;
        check("t4_idle_sp", running, 0);
        pulse_start();
        step();
        start = 1'b1; pause = 1'b1; step();
        start = 1'b0; pause = 1'b0;
        check("t4_run_sp", running, 0);
        pulse_start();
        n = 0;
        while (!done && n < 60) begin step(); n++; end
        check("t4_done", done, 1);
        check("t4_target", sec_u, 2);

        // 3: pause after two prescaler counts, resume keeps partial second
        do_clear();
        load(0, 0, 0, 0);
        pulse_start();
        step(); step();
        pause = 1'b1; step(); pause = 1'b0;
        repeat (10) step();
        pulse_start();
        n = 0;
        while (!tick_1hz && n < 20) begin step(); n++; end
        check("t3_resume_tick", n, 2);

        // random mix of controls and targets
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 4) == 0;
            pause = ($urandom % 10) == 0;
            clear = ($urandom % 80) == 0;
            load_target = ($urandom % 16) == 0;
            tmt = 4'd0;
            tmu = 4'($urandom % 2);
            tst = 4'($urandom % 6);
            tsu = 4'($urandom % 10);
            if (($urandom % 8) == 0) tst = 4'(6 + $urandom % 10);
            if (($urandom % 8) == 0) tsu = 4'(10 + $urandom % 6);
            step();
        end
        start = 0; pause = 0; clear = 0; load_target = 0;

        // 6: async reset mid-run at 00:07
        do_clear();
        load(0, 0, 0, 9);
        pulse_start();
        n = 0;
        while (m_secs != 7 && n < 60) begin step(); n++; end
        check("t6_at_7", {min_t, min_u, sec_t, sec_u}, 16'h0007);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("t6_async", {min_t, min_u, sec_t, sec_u,
              tick_1hz, running, done, target_err}, 0);
        #4;
        rst_n = 1'b1;
        model_reset();
        pulse_start();
        repeat (11 * T) step();
        check("t6_no_target", done, 0);

        // 2: free-run through 99:59 -> 00:00
        wrapped = 0;
        for (int i = 0; i < 6000 * T + 50 && !wrapped; i++) begin
            prev = m_secs;
            step();
            if (prev == 5999 && m_secs == 0) wrapped = 1;
        end
        check("t2_wrap_seen", int'(wrapped), 1);
        check("t2_wrap_digits", {min_t, min_u, sec_t, sec_u}, 0);
        check("t2_no_done", done, 0);
        repeat (2 * T) step();
        check("t2_after", {min_t, min_u, sec_t, sec_u}, 16'h0002);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
